// File: rtl/prog_interval_timer_pkg.sv
// Shared constants for the programmable interval timer: mode encoding and FSM state codes.
package prog_interval_timer_pkg;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/prog_interval_timer_if.sv
// Control/status bundle between a timer client (master) and the interval timer (slave).
interface prog_interval_timer_if #(
    parameter int WIDTH = 16
);

    logic             tick;
    logic             start;
    logic             stop;
    logic             mode;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] count;
    logic             timeout;
    logic             busy;
    logic             period_err;

    modport master (
        output tick, start, stop, mode, period,
        input  count, timeout, busy, period_err
    );

    modport slave (
        input  tick, start, stop, mode, period,
        output count, timeout, busy, period_err
    );

endinterface

// File: rtl/prog_interval_timer.sv
// Runtime-programmable interval timer: counts qualified ticks up to a loadable terminal
// count and emits a one-cycle timeout pulse, in periodic or one-shot mode.
module prog_interval_timer
    import prog_interval_timer_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int DEFAULT_PERIOD = 100,
    parameter bit USE_TICK       = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prog_interval_timer_if.slave tmr
);

    // Only period-1 is kept: the sampled period itself is never needed once the terminal is known.
    localparam logic [WIDTH-1:0] DEF_TERM = WIDTH'(DEFAULT_PERIOD - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             mode_q, mode_d;
    logic             timeout_q, timeout_d;
    logic             period_err_q, period_err_d;
    logic             tick_en;

    assign tick_en = USE_TICK ? tmr.tick : 1'b1;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        term_d       = term_q;
        mode_d       = mode_q;
        timeout_d    = 1'b0;
        period_err_d = 1'b0;

        if (tmr.stop) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (tmr.start) begin
            count_d = '0;
            if (tmr.period != '0) begin
                term_d  = tmr.period - WIDTH'(1);
                mode_d  = tmr.mode;
                state_d = ST_RUN;
            end else begin
                period_err_d = 1'b1;
                state_d      = ST_IDLE;
            end
        end else if (state_q == ST_RUN && tick_en) begin
            // Terminal compare uses the registered term so it stays off the incrementer path.
            if (count_q == term_q) begin
                count_d   = '0;
                timeout_d = 1'b1;
                if (mode_q == MODE_ONESHOT) begin
                    state_d = ST_IDLE;
                end
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            term_q       <= DEF_TERM;
            mode_q       <= MODE_PERIODIC;
            timeout_q    <= 1'b0;
            period_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            term_q       <= term_d;
            mode_q       <= mode_d;
            timeout_q    <= timeout_d;
            period_err_q <= period_err_d;
        end
    end

    assign tmr.count      = count_q;
    assign tmr.timeout    = timeout_q;
    assign tmr.busy       = (state_q == ST_RUN);
    assign tmr.period_err = period_err_q;

endmodule

// File: tb/tb_prog_interval_timer.sv
// Directed bench for prog_interval_timer; timeout pulses are checked against a queue of
// expected cycle numbers filled as the ticks that should cause them are driven.
module tb_prog_interval_timer;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int tickNo  = 0;
    int firstTo = 0;
    int lastTo  = 0;
    int expQ[$];

    prog_interval_timer_if #(.WIDTH(W)) if0 ();
    prog_interval_timer_if #(.WIDTH(W)) if1 ();

    prog_interval_timer #(.WIDTH(W), .DEFAULT_PERIOD(100), .USE_TICK(1'b1)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .tmr   (if0.slave)
    );

    prog_interval_timer #(.WIDTH(W), .DEFAULT_PERIOD(100), .USE_TICK(1'b0)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .tmr   (if1.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every timeout pulse must match the oldest expected cycle; a pulse with nothing queued fails.
    always @(negedge clk) begin
        int expCyc;
        if (rst_n === 1'b1 && if0.timeout === 1'b1) begin
            checks++;
            expCyc = (expQ.size() != 0) ? expQ.pop_front() : -1;
            assert (cyc == expCyc) else begin
                errors++;
                $error("[TB] FAIL timeout_cycle observed=%0d expected=%0d", cyc, expCyc);
            end
            lastTo = cyc;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic sp, input logic md,
                                 input logic [W-1:0] per, input logic tk);
        if0.start  = st;
        if0.stop   = sp;
        if0.mode   = md;
        if0.period = per;
        if0.tick   = tk;
        @(negedge clk);
    endtask

    // Junk period/mode while idling shows they are ignored outside a start.
    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd7, 1'b0);
    endtask

    task automatic tickRun(input int n, input int gap, input int per, input logic oneShot);
        for (int i = 0; i < n; i++) begin
            tickNo++;
            if ((!oneShot && (tickNo % per) == 0) || (oneShot && tickNo == per))
                expQ.push_back(cyc + 1);
            applyStimulus(1'b0, 1'b0, 1'b1, 16'd7, 1'b1);
            repeat (gap - 1) idle();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        if0.start = 1'b0; if0.stop = 1'b0; if0.mode = 1'b0; if0.period = '0; if0.tick = 1'b0;
        if1.start = 1'b0; if1.stop = 1'b0; if1.mode = 1'b0; if1.period = '0; if1.tick = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_count",   32'(if0.count), 0);
        checkOutput("rst_busy",    32'(if0.busy), 0);
        checkOutput("rst_timeout", 32'(if0.timeout), 0);
        checkOutput("rst_perr",    32'(if0.period_err), 0);
        checkOutput("rst_busy1",   32'(if1.busy), 0);

        $display("[TB] periodic N=100, tick every 4 clks");
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd100, 1'b1);
        tickNo = 0;
        checkOutput("per_busy",   32'(if0.busy), 1);
        checkOutput("per_count0", 32'(if0.count), 0);
        idle();
        tickRun(99, 4, 100, 1'b0);
        checkOutput("per_count99", 32'(if0.count), 99);
        tickNo++;
        expQ.push_back(cyc + 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd7, 1'b1);
        firstTo = cyc;
        checkOutput("per_to_hi",   32'(if0.timeout), 1);
        checkOutput("per_wrap",    32'(if0.count), 0);
        checkOutput("per_busy_to", 32'(if0.busy), 1);
        idle();
        checkOutput("per_to_width", 32'(if0.timeout), 0);
        idle();
        idle();
        tickRun(100, 4, 100, 1'b0);
        checkOutput("per_interval", 32'(lastTo - firstTo), 400);

        $display("[TB] one-shot N=5");
        applyStimulus(1'b1, 1'b0, 1'b1, 16'd5, 1'b0);
        tickNo = 0;
        checkOutput("os_busy", 32'(if0.busy), 1);
        tickRun(4, 2, 5, 1'b1);
        tickNo++;
        expQ.push_back(cyc + 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd7, 1'b1);
        checkOutput("os_to",        32'(if0.timeout), 1);
        checkOutput("os_busy_fall", 32'(if0.busy), 0);
        tickRun(6, 2, 5, 1'b1);
        checkOutput("os_idle_count", 32'(if0.count), 0);
        checkOutput("os_idle_busy",  32'(if0.busy), 0);

        $display("[TB] restart at count=50 with period=20");
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd100, 1'b0);
        tickNo = 0;
        tickRun(50, 1, 100, 1'b0);
        checkOutput("rs_count50", 32'(if0.count), 50);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd20, 1'b1);
        tickNo = 0;
        checkOutput("rs_count0", 32'(if0.count), 0);
        checkOutput("rs_busy",   32'(if0.busy), 1);
        tickRun(19, 2, 20, 1'b0);
        checkOutput("rs_count19", 32'(if0.count), 19);
        tickRun(1, 1, 20, 1'b0);
        checkOutput("rs_to",    32'(if0.timeout), 1);
        checkOutput("rs_wrap",  32'(if0.count), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd20, 1'b1);
        checkOutput("stop_busy",  32'(if0.busy), 0);
        checkOutput("stop_count", 32'(if0.count), 0);
        checkOutput("stop_to",    32'(if0.timeout), 0);

        $display("[TB] period=0 and start+stop");
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
        checkOutput("pe_pulse", 32'(if0.period_err), 1);
        checkOutput("pe_busy",  32'(if0.busy), 0);
        idle();
        checkOutput("pe_width", 32'(if0.period_err), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd10, 1'b0);
        tickNo = 0;
        tickRun(3, 1, 10, 1'b0);
        checkOutput("pe_run_count", 32'(if0.count), 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
        checkOutput("pe_run_pulse", 32'(if0.period_err), 1);
        checkOutput("pe_run_busy",  32'(if0.busy), 0);
        checkOutput("pe_run_count0", 32'(if0.count), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd10, 1'b0);
        checkOutput("ss_busy", 32'(if0.busy), 0);
        checkOutput("ss_perr", 32'(if0.period_err), 0);
        tickNo = 0;
        tickRun(12, 1, 1000000, 1'b1);
        checkOutput("ss_count", 32'(if0.count), 0);

        $display("[TB] async reset mid-clock");
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd100, 1'b0);
        tickNo = 0;
        tickRun(7, 1, 100, 1'b0);
        checkOutput("ar_count7", 32'(if0.count), 7);
        checkOutput("ar_busy1",  32'(if0.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("ar_count", 32'(if0.count), 0);
        checkOutput("ar_busy",  32'(if0.busy), 0);
        checkOutput("ar_to",    32'(if0.timeout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        checkOutput("ar_after_busy", 32'(if0.busy), 0);

        $display("[TB] N=1 periodic, free-running count");
        if1.start = 1'b1; if1.period = 16'd1; if1.mode = 1'b0;
        @(negedge clk);
        if1.start = 1'b0; if1.period = 16'd9; if1.mode = 1'b1;
        checkOutput("n1_first", 32'(if1.timeout), 0);
        checkOutput("n1_busy",  32'(if1.busy), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("n1_to",    32'(if1.timeout), 1);
            checkOutput("n1_count", 32'(if1.count), 0);
        end
        if1.stop = 1'b1;
        @(negedge clk);
        if1.stop = 1'b0;
        checkOutput("n1_stop_to",   32'(if1.timeout), 0);
        checkOutput("n1_stop_busy", 32'(if1.busy), 0);
        @(negedge clk);
        checkOutput("n1_stay_low", 32'(if1.timeout), 0);

        checkOutput("sb_drained", 32'(expQ.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
